// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with a sequential multiply/divide unit and HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module alu_control_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       Func,
  input  logic             issue,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [2:0]       AluCtrl,
  output logic             illegal,
  output logic             md_busy,
  output logic             stall,
  output logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_raw;
  logic             is_div, neg_q, neg_r, dz;

  logic md, mf_hi, mf_lo, mt_hi, mt_lo, accept;

  always_comb begin
    AluCtrl = 3'b010;
    illegal = 1'b0;
    md      = 1'b0;
    mf_hi   = 1'b0;
    mf_lo   = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    if (!AluOp[1]) begin
      AluCtrl = AluOp[0] ? 3'b110 : 3'b010;
    end else begin
      case (Func)
        6'b100000: AluCtrl = 3'b010;
        6'b100010: AluCtrl = 3'b110;
        6'b100100: AluCtrl = 3'b000;
        6'b100101: AluCtrl = 3'b001;
        6'b100110: AluCtrl = 3'b011;
        6'b101010: AluCtrl = 3'b111;
        6'b011000, 6'b011001, 6'b011010, 6'b011011: md = 1'b1;
        6'b010000: mf_hi = 1'b1;
        6'b010010: mf_lo = 1'b1;
        6'b010001: mt_hi = 1'b1;
        6'b010011: mt_lo = 1'b1;
        default:   illegal = 1'b1;
      endcase
    end
  end

  // Handshake: issue marks a valid EX instruction; stall holds it in place.
  // An instruction is consumed on a rising edge where issue & !stall.
  assign stall      = issue & md_busy & (md | mf_hi | mf_lo | mt_hi | mt_lo);
  assign accept     = issue & ~stall;
  assign hilo_sel   = accept & (mf_hi | mf_lo);
  assign hilo_rdata = mf_hi ? hi : (mf_lo ? lo : '0);

  // Operand preparation: Func[0]=0 selects the signed variants, Func[1]=1 the divides.
  logic             op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    op_signed = ~Func[0];
    op_div    = Func[1];
    a_neg     = op_signed & src_a[WIDTH-1];
    b_neg     = op_signed & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
  end

  // One iteration: multiply adds then shifts right; divide shifts left and trial-subtracts.
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    step_hi  = mul_sum[WIDTH:1];
    step_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_sh[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_s = neg_q ? -prod : prod;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        res_lo = '1;
        res_hi = a_raw;
      end else begin
        res_lo = neg_q ? -acc_lo : acc_lo;
        res_hi = neg_r ? -acc_hi : acc_hi;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept & md) begin
            state   <= S_RUN;
            cnt     <= '0;
            md_busy <= 1'b1;
            acc_hi  <= '0;
            acc_lo  <= op_div ? a_mag : b_mag;
            opnd    <= op_div ? b_mag : a_mag;
            a_raw   <= src_a;
            is_div  <= op_div;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            dz      <= op_div & (src_b == '0);
          end
          if (accept & mt_hi) hi <= src_a;
          if (accept & mt_lo) lo <= src_a;
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi      <= res_hi;
          lo      <= res_lo;
          md_busy <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode table, directed MD corner cases, stall timing,
// reset abort and randomized MD ops against a wide-integer arithmetic model.
module tb_alu_control_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   AluOp;
  logic [5:0]   Func;
  logic         issue;
  logic [W-1:0] src_a, src_b;
  logic [2:0]   AluCtrl;
  logic         illegal, md_busy, stall, hilo_sel;
  logic [W-1:0] hilo_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  alu_control_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .AluOp(AluOp), .Func(Func), .issue(issue),
    .src_a(src_a), .src_b(src_b), .AluCtrl(AluCtrl), .illegal(illegal),
    .md_busy(md_busy), .stall(stall), .hilo_sel(hilo_sel), .hilo_rdata(hilo_rdata)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: plain wide-integer arithmetic
  task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint       sa, sb, sp;
    logic [63:0]  p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (f)
      6'h18: begin sp = sa * sb; p = sp; {hi, lo} = p; end
      6'h19: begin p = {32'b0, a} * {32'b0, b}; {hi, lo} = p; end
      6'h1a: begin
        if (b == '0) begin lo = '1; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = q[W-1:0]; hi = r[W-1:0]; end
      end
      default: begin
        if (b == '0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic iss,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    AluOp = op; Func = f; issue = iss; src_a = a; src_b = b;
  endtask

  task automatic idle();
    drive(2'b00, 6'h00, 1'b0, '0, '0);
  endtask

  task automatic read_hilo(input logic is_hi, input string tag, input logic [W-1:0] exp);
    drive(2'b10, is_hi ? 6'h10 : 6'h12, 1'b1, '0, '0);
    #2;
    check({tag, "_sel"}, hilo_sel, 1);
    check(tag, hilo_rdata, exp);
    tick();
    idle();
  endtask

  task automatic read_result(input string tag);
    logic [W-1:0] e_lo, e_hi;
    if (exp_q.size() < 2) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_queue: got=%0d exp=2 entries", tag, exp_q.size());
    end else begin
      e_lo = exp_q.pop_front();
      e_hi = exp_q.pop_front();
      read_hilo(1'b0, {tag, "_lo"}, e_lo);
      read_hilo(1'b1, {tag, "_hi"}, e_hi);
    end
  endtask

  // issue one MD op, check its busy window, push model results onto the scoreboard
  task automatic md_run(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    int busy_cnt;
    logic [W-1:0] m_hi, m_lo;
    busy_cnt = 0;
    drive(2'b10, f, 1'b1, a, b);
    #2;
    check({tag, "_accept_stall"}, stall, 0);
    tick();
    idle();
    for (int c = 1; c <= W + 1; c++) begin
      #2;
      if (md_busy) busy_cnt++;
      tick();
    end
    #2;
    check({tag, "_busy_len"}, busy_cnt, W + 1);
    check({tag, "_busy_end"}, md_busy, 0);
    tick();
    model(f, a, b, m_hi, m_lo);
    exp_q.push_back(m_lo);
    exp_q.push_back(m_hi);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  logic [5:0] dec_f [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a,
                             6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h07};
  logic [2:0] dec_c [12] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};

  initial begin
    int cnt_a, cnt_b;
    logic [W-1:0] m_hi, m_lo;

    // reset
    rst_n = 1'b0;
    drive(2'b10, 6'h10, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #3;
    check("rst_busy", md_busy, 0);
    check("rst_stall", stall, 0);
    check("rst_hilo_sel", hilo_sel, 0);
    check("rst_hilo_rdata", hilo_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle();

    // decode table
    drive(2'b00, 6'h07, 1'b0, '0, '0); #2;
    check("dec_add_ctrl", AluCtrl, 3'b010);
    check("dec_add_ill", illegal, 0);
    drive(2'b01, 6'h07, 1'b0, '0, '0); #2;
    check("dec_sub_ctrl", AluCtrl, 3'b110);
    check("dec_sub_ill", illegal, 0);
    for (int i = 0; i < 12; i++) begin
      drive(2'b10, dec_f[i], 1'b0, '0, '0);
      #2;
      check($sformatf("dec_ctrl_%h", dec_f[i]), AluCtrl, dec_c[i]);
      check($sformatf("dec_ill_%h", dec_f[i]), illegal, (dec_f[i] == 6'h07) ? 1 : 0);
    end
    drive(2'b11, 6'h2a, 1'b0, '0, '0); #2;
    check("dec_11_slt", AluCtrl, 3'b111);
    tick();
    idle();

    // directed MD corner cases
    md_run(6'h18, 32'hFFFF_FFFE, 32'h0000_0003, "mult_m2x3");
    read_result("mult_m2x3");
    md_run(6'h1a, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7d2");
    read_result("div_m7d2");
    md_run(6'h1b, 32'h0000_0007, 32'h0000_0000, "divu_7d0");
    read_result("divu_7d0");
    md_run(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    read_result("div_ovf");
    md_run(6'h1a, 32'hFFFF_FFFB, 32'h0000_0000, "div_m5d0");
    read_result("div_m5d0");

    // MFLO held while MULTU runs
    drive(2'b10, 6'h19, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(2'b10, 6'h12, 1'b1, '0, '0);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 1; c <= W + 1; c++) begin
      #2;
      if (stall) cnt_a++;
      if (hilo_sel) cnt_b++;
      tick();
    end
    #2;
    model(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m_hi, m_lo);
    check("mflo_stall_len", cnt_a, W + 1);
    check("mflo_sel_early", cnt_b, 0);
    check("mflo_release_stall", stall, 0);
    check("mflo_release_sel", hilo_sel, 1);
    check("mflo_release_data", hilo_rdata, m_lo);
    tick();
    read_hilo(1'b1, "multu_hi", m_hi);

    // non-MD instruction and MTHI while busy
    drive(2'b10, 6'h18, 1'b1, 32'd3, 32'd4);
    tick();
    drive(2'b00, 6'h00, 1'b1, '0, '0);
    #2;
    check("add_busy_stall", stall, 0);
    check("add_busy_ctrl", AluCtrl, 3'b010);
    tick();
    drive(2'b10, 6'h11, 1'b1, 32'h1234, '0);
    cnt_a = 0;
    for (int c = 2; c <= W + 1; c++) begin
      #2;
      if (stall) cnt_a++;
      tick();
    end
    #2;
    check("mthi_stall_len", cnt_a, W);
    check("mthi_release", stall, 0);
    tick();
    idle();
    read_hilo(1'b1, "mthi_hi", 32'h1234);
    read_hilo(1'b0, "mthi_lo", 32'd12);

    // reset in the middle of a divide
    drive(2'b10, 6'h11, 1'b1, 32'd5, '0); tick();
    drive(2'b10, 6'h13, 1'b1, 32'd6, '0); tick();
    idle();
    read_hilo(1'b1, "preload_hi", 32'd5);
    read_hilo(1'b0, "preload_lo", 32'd6);
    drive(2'b10, 6'h1a, 1'b1, 32'd100, 32'd7);
    tick();
    idle();
    repeat (9) tick();
    #2;
    check("abort_busy_before", md_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_now", md_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cnt_a = 0;
    for (int c = 0; c < W + 8; c++) begin
      #2;
      if (md_busy) cnt_a++;
      tick();
    end
    check("abort_no_busy", cnt_a, 0);
    read_hilo(1'b1, "abort_hi", '0);
    read_hilo(1'b0, "abort_lo", '0);
    md_run(6'h18, 32'd3, 32'd4, "mult_3x4");
    read_result("mult_3x4");

    // randomized MD ops
    for (int n = 0; n < 16; n++) begin
      logic [5:0] f;
      logic [W-1:0] a, b;
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = pick();
      b = pick();
      md_run(f, a, b, $sformatf("rnd%0d_f%h", n, f));
      read_result($sformatf("rnd%0d_f%h_a%h_b%h", n, f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
Parametrised successor to the EX-stage ALU control decoder. It keeps the AluOp/Func to AluCtrl decode and adds a sequential multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers. It also handles the MFHI, MFLO, MTHI and MTLO moves and generates the pipeline stall while the unit is busy. It sits in the EX stage beside the ALU; hilo_rdata feeds the EX result mux.

Parameters:
WIDTH, 32, datapath width of src_a, src_b, HI, LO and hilo_rdata (>= 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
AluOp  input  2  main-decoder ALU class: 00 add, 01 sub, 1x R-type (decode Func)
Func  input  6  instruction funct field
issue  input  1  valid instruction in EX this cycle
src_a  input  WIDTH  rs operand (multiplicand / dividend / MT source)
src_b  input  WIDTH  rt operand (multiplier / divisor)
AluCtrl  output  3  ALU operation select (combinational)
illegal  output  1  R-type funct not recognised (combinational)
md_busy  output  1  multiply/divide in progress (registered)
stall  output  1  hold IF/ID/EX this cycle (combinational)
hilo_sel  output  1  EX result comes from hilo_rdata (MFHI/MFLO)
hilo_rdata  output  WIDTH  HI for MFHI, LO for MFLO, else 0

Behaviour:
- Decode (combinational, complete, no latches):
  - AluOp=00 -> 010. AluOp=01 -> 110.
  - AluOp[1]=1: 100000->010, 100010->110, 100100->000, 100101->001, 100110->011, 101010->111.
  - MD/move functs: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO. These give AluCtrl=010 and illegal=0.
  - Any other funct with AluOp[1]=1 gives AluCtrl=010 and illegal=1. illegal=0 whenever AluOp[1]=0.
- The md/mf/mt classes are recognised only when AluOp[1]=1.
- stall = issue & md_busy & (md | mf | mt). Non-MD instructions never stall, even while busy.
- Accept condition: issue & !stall.
  - MD op: latch operands and op type, go to RUN.
  - MTHI/MTLO: HI (or LO) <= src_a at that edge.
- hilo_sel = issue & mf & !stall.
- hilo_rdata shows current HI/LO. It reads old values only when not busy, which the stall guarantees.
- FSM IDLE -> RUN -> FIX -> IDLE.
  - IDLE: accept MD op -> RUN, counter = 0.
  - RUN: one radix-2 step per cycle for exactly WIDTH cycles. Multiply is shift-add; divide is restoring. Then go to FIX.
  - FIX: apply sign correction, write HI/LO at the end of this cycle, go to IDLE.
  - md_busy = (state != IDLE).
- Timing with accept at cycle 0:
  - md_busy is high in cycles 1..WIDTH+1.
  - HI/LO are new from cycle WIDTH+2.
  - An MFLO issued in cycles 1..WIDTH+1 stalls and completes in cycle WIDTH+2.
- Signed ops run on magnitudes, then negate in FIX.
  - Product sign = a[W-1]^b[W-1].
  - Quotient sign = a[W-1]^b[W-1], truncating toward zero. Remainder sign = dividend sign.
- MULT/MULTU: {HI,LO} = 2*WIDTH-bit product. DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (deterministic): LO = all ones, HI = src_a unchanged. Both signed and unsigned; no exception.
- Signed overflow: -2^(W-1) / -1 gives LO = 0x80..0, HI = 0.
- Register-write guard: an MD op issued while busy is not accepted (it stalls). No two state updates collide; MT while busy also stalls.
- Reset (async assert, synchronous-safe deassert):
  - State IDLE, counter 0, HI = LO = 0.
  - md_busy = 0, so stall = 0 and hilo_sel = 0; hilo_rdata = 0.
  - Reset mid-operation aborts the operation with no HI/LO write.
- issue=0: no accept and no stall. An MD op in RUN/FIX continues regardless of issue.

Test Plan:
- AluOp=00/01, then AluOp=10 with each listed funct, then funct 000111 -> AluCtrl 010/110/010,110,000,001,011,111; illegal=1 only for 000111.
- WIDTH=32, MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> md_busy high cycles 1..33; MFHI/MFLO after -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV src_a=-7, src_b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, MFLO issued in cycle 1 and held -> stall=1 cycles 1..33; cycle 34: stall=0, hilo_sel=1, hilo_rdata=0x00000001; then MFHI -> 0xFFFFFFFE.
- ADD issued while busy -> stall=0, AluCtrl=010. MTHI src_a=0x1234 while busy -> stalls until idle, then HI=0x1234.
- rst_n low in cycle 10 of DIV after HI/LO were loaded with 5/6 -> md_busy=0 immediately, HI=LO=0, no later write; a new MULT 3*4 afterwards gives LO=12.
